// File: rtl/long_muldiv_unit.sv
// Multi-cycle signed/unsigned multiply and divide, one result bit per cycle.
// Flow: IDLE (accept) -> PREP (magnitudes) -> RUN (WIDTH steps) -> FIX (signs/flags) -> DONE (hold).
module long_muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_oper,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             out_n,
    output logic             out_z,
    output logic             out_dbz,
    output logic             out_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_oper;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_res;
    logic             r_neg_rem;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_hi;
    logic [WIDTH-1:0] r_out_lo;
    logic             r_out_n;
    logic             r_out_z;
    logic             r_out_dbz;
    logic             r_out_ovf;

    logic               w_is_div;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic               w_dbz;
    logic               w_ovf;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic               w_fix_n;
    logic               w_fix_dbz;
    logic               w_fix_ovf;

    assign in_ready = reset_n && (r_state == S_IDLE) && !flush;

    assign w_is_div = r_oper[1];
    assign w_sa     = r_oper[0] & r_a[WIDTH-1];
    assign w_sb     = r_oper[0] & r_b[WIDTH-1];
    assign w_a_mag  = w_sa ? -r_a : r_a;
    assign w_b_mag  = w_sb ? -r_b : r_b;

    // Both datapaths share r_hi:r_lo; r_m holds the multiplicand or divisor magnitude.
    assign w_mul_sum = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_m}) : {1'b0, r_hi};
    assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge  = (w_rem_sh >= {1'b0, r_m});
    assign w_rem_nxt = w_div_ge ? WIDTH'(w_rem_sh - {1'b0, r_m}) : w_rem_sh[WIDTH-1:0];

    assign w_dbz  = w_is_div && (r_b == '0);
    assign w_ovf  = (r_oper == 2'b11) && (r_a == MOST_NEG) && (r_b == '1);
    assign w_prod = r_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo  = r_neg_res ? -r_lo : r_lo;
    assign w_rem  = r_neg_rem ? -r_hi : r_hi;

    always_comb begin
        w_fix_hi  = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo  = w_prod[WIDTH-1:0];
        w_fix_n   = w_prod[2*WIDTH-1];
        w_fix_dbz = 1'b0;
        w_fix_ovf = 1'b0;
        if (w_is_div) begin
            if (w_dbz) begin
                w_fix_hi = r_a;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quo;
            end
            w_fix_n   = w_fix_lo[WIDTH-1];
            w_fix_dbz = w_dbz;
            w_fix_ovf = w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_oper      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_m         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_hi    <= '0;
            r_out_lo    <= '0;
            r_out_n     <= 1'b0;
            r_out_z     <= 1'b0;
            r_out_dbz   <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (flush && (r_state != S_IDLE)) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_oper  <= in_oper;
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_hi      <= '0;
                    r_lo      <= w_a_mag;
                    r_m       <= w_b_mag;
                    r_neg_res <= w_sa ^ w_sb;
                    r_neg_rem <= w_sa;
                    r_cnt     <= CNT_INIT;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (w_is_div) begin
                        r_hi <= w_rem_nxt;
                        r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
                    end else begin
                        {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
                    end
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_FIX: begin
                    r_out_hi    <= w_fix_hi;
                    r_out_lo    <= w_fix_lo;
                    r_out_n     <= w_fix_n;
                    r_out_z     <= ({w_fix_hi, w_fix_lo} == '0);
                    r_out_dbz   <= w_fix_dbz;
                    r_out_ovf   <= w_fix_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_hi    = r_out_hi;
    assign out_lo    = r_out_lo;
    assign out_n     = r_out_n;
    assign out_z     = r_out_z;
    assign out_dbz   = r_out_dbz;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_long_muldiv_unit.sv
// Bench for long_muldiv_unit: directed spec vectors, abort cases and randomized traffic,
// all compared every cycle against an arithmetic reference model.
module tb_long_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_oper;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_hi;
    logic [W-1:0]  out_lo;
    logic          out_n;
    logic          out_z;
    logic          out_dbz;
    logic          out_ovf;

    long_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_oper   (in_oper),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .out_n     (out_n),
        .out_z     (out_z),
        .out_dbz   (out_dbz),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        n;
        logic        z;
        logic        dbz;
        logic        ovf;
    } res_t;

    function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [63:0] p;
        longint      sp;
        int          sa;
        int          sb;
        r = '0;
        case (op)
            2'b00: begin
                p = {32'h0, a} * {32'h0, b};
                {r.hi, r.lo} = p;
            end
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {r.hi, r.lo} = sp;
            end
            2'b10: begin
                if (b == 32'h0) begin
                    r.lo = 32'hFFFF_FFFF; r.hi = a; r.dbz = 1'b1;
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
            default: begin
                if (b == 32'h0) begin
                    r.lo = 32'hFFFF_FFFF; r.hi = a; r.dbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000; r.hi = 32'h0; r.ovf = 1'b1;
                end else begin
                    sa = a; sb = b;
                    r.lo = sa / sb; r.hi = sa % sb;
                end
            end
        endcase
        r.n = op[1] ? r.lo[31] : r.hi[31];
        r.z = ({r.hi, r.lo} == 64'h0);
        return r;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference tracker and per-cycle comparison.
    logic live     = 1'b0;
    logic rst_seen = 1'b0;
    logic exp_ready;
    logic exp_valid;
    int   cnt      = 0;
    res_t exp_r    = '0;

    always @(negedge clk) begin
        if (live) cnt++;
        exp_ready = reset_n && !live && !flush;
        exp_valid = live && (cnt >= LAT);
        check("in_ready", 72'(in_ready), 72'(exp_ready));
        check("out_valid", 72'(out_valid), 72'(exp_valid));
        if (exp_valid) begin
            check("out_hi", 72'(out_hi), 72'(exp_r.hi));
            check("out_lo", 72'(out_lo), 72'(exp_r.lo));
            check("flags_nzdo", 72'({out_n, out_z, out_dbz, out_ovf}),
                  72'({exp_r.n, exp_r.z, exp_r.dbz, exp_r.ovf}));
        end
        if (rst_seen) begin
            check("reset_clear", 72'({out_valid, out_hi, out_lo, out_n, out_z, out_dbz, out_ovf}), 72'(0));
        end
        rst_seen = !reset_n;
        if (!reset_n) begin
            live = 1'b0;
        end else if (live) begin
            if (flush || (exp_valid && out_ready)) live = 1'b0;
        end else if (in_valid && exp_ready) begin
            live  = 1'b1;
            cnt   = -1;
            exp_r = model(in_oper, in_a, in_b);
        end
    end

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: got in_ready=0, want 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_oper  = 2'($urandom_range(0, 3));
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_oper = op; in_a = a; in_b = b;
        wait_accept();
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int n = 0; n < LAT + 20; n++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL result_timeout: got out_valid=0, want 1 within %0d cycles", LAT + 20);
        end
    endtask

    task automatic recv(input int hold);
        wait_valid();
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        send(op, a, b);
        recv(hold);
    endtask

    res_t pr;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_oper = 2'b00; in_a = '0; in_b = '0;
        flush = 1'b0; out_ready = 1'b0;

        pr = model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("pin_umul_max", 72'({pr.hi, pr.lo}), 72'(64'hFFFF_FFFE_0000_0001));
        pr = model(2'b01, 32'hFFFF_FFFD, 32'd7);
        check("pin_smul", 72'({pr.hi, pr.lo, pr.n, pr.z}), 72'({64'hFFFF_FFFF_FFFF_FFEB, 2'b10}));
        pr = model(2'b00, 32'h0, 32'h1234_5678);
        check("pin_umul_zero", 72'(pr.z), 72'(1));
        pr = model(2'b10, 32'd100, 32'd7);
        check("pin_udiv", 72'({pr.hi, pr.lo}), 72'(64'h0000_0002_0000_000E));
        pr = model(2'b11, 32'hFFFF_FFF9, 32'd2);
        check("pin_sdiv", 72'({pr.hi, pr.lo}), 72'(64'hFFFF_FFFF_FFFF_FFFD));
        pr = model(2'b11, 32'd7, 32'hFFFF_FFFE);
        check("pin_sdiv_pos", 72'({pr.hi, pr.lo}), 72'(64'h0000_0001_FFFF_FFFD));
        pr = model(2'b10, 32'd5, 32'h0);
        check("pin_dbz", 72'({pr.hi, pr.lo, pr.dbz, pr.ovf}), 72'({64'h0000_0005_FFFF_FFFF, 2'b10}));
        pr = model(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check("pin_ovf", 72'({pr.hi, pr.lo, pr.dbz, pr.ovf}), 72'({64'h0000_0000_8000_0000, 2'b01}));

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(2'b01, 32'hFFFF_FFFD, 32'd7, 2);
        run(2'b00, 32'h0, 32'h1234_5678, 0);
        run(2'b10, 32'd100, 32'd7, 1);
        run(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        run(2'b10, 32'd5, 32'h0, 0);
        run(2'b11, 32'hFFFF_FFFB, 32'h0, 0);
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        run(2'b00, 32'h8000_0000, 32'h0000_0002, 0);

        // Backpressure in DONE, then a back-to-back request queued on the handshake.
        send(2'b10, 32'hDEAD_BEEF, 32'h0000_1234);
        wait_valid();
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_oper = 2'b01; in_a = 32'hFFFF_FF00; in_b = 32'h0000_0100;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_accept();
        recv(0);

        // Flush during RUN.
        send(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (6) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (LAT + 5) @(posedge clk);

        // Flush in IDLE blocks a same-cycle request.
        #1 flush = 1'b1; in_valid = 1'b1; in_oper = 2'b10; in_a = 32'd77; in_b = 32'd5;
        @(posedge clk); #1 flush = 1'b0;
        wait_accept();
        recv(0);

        // Reset in the middle of RUN.
        send(2'b11, 32'h8765_4321, 32'h0000_0033);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run(2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_oper   = 2'($urandom_range(0, 3));
            in_a      = rnd_opnd();
            in_b      = rnd_opnd();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (LAT + 5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
